// File: rtl/game_pkg.sv
// Shared game-logic types and sprite sizes for the cheese placement and scoring stage.
package game_pkg;
  localparam int CHEESE_WIDTH  = 32;
  localparam int CHEESE_HEIGHT = 32;
  localparam int JERRY_WIDTH   = 40;
  localparam int JERRY_HEIGHT  = 48;

  typedef enum logic [2:0] {IDLE, PLACE, COMMIT, SHOW, EATEN} cheese_state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } pos_if;

  // Strict box overlap on 12 bits so x+width never wraps; touching edges do not count.
  function automatic logic overlap(input logic [10:0] cx, input logic [10:0] cy,
                                   input logic [10:0] jx, input logic [10:0] jy);
    return ({1'b0, jx} < {1'b0, cx} + 12'(CHEESE_WIDTH)) &&
           ({1'b0, jx} + 12'(JERRY_WIDTH) > {1'b0, cx}) &&
           ({1'b0, jy} < {1'b0, cy} + 12'(CHEESE_HEIGHT)) &&
           ({1'b0, jy} + 12'(JERRY_HEIGHT) > {1'b0, cy});
  endfunction
endpackage

// File: rtl/cheese_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11); an all-zero seed is replaced by 1.
module cheese_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (rst) value <= SEED_NZ;
    else     value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
  end
endmodule

// File: rtl/cheese_ctl.sv
// Cheese placement, Jerry hit detection, scoring and frame-aligned position commit.
// Optional CHEESE_TIMEOUT_EN: unclaimed cheese relocates after TIMEOUT_FRAMES frames.
module cheese_ctl
  import game_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [10:0] X_MIN     = 11'd16,
  parameter logic [10:0] X_MAX     = 11'd1000,
  parameter logic [10:0] Y_MIN     = 11'd64,
  parameter logic [10:0] Y_MAX     = 11'd740,
  parameter logic [10:0] CHEESE_X0 = 11'd500,
  parameter logic [10:0] CHEESE_Y0 = 11'd400,
  parameter logic [5:0]  RETRY_MAX = 6'd32,
  parameter int          SCORE_W   = 8
`ifdef CHEESE_TIMEOUT_EN
  , parameter logic [9:0] TIMEOUT_FRAMES = 10'd600
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               vblnk,
  input  logic [10:0]        jerry_x,
  input  logic [10:0]        jerry_y,
  output pos_if              pout,
  output logic [SCORE_W-1:0] score,
  output logic               eaten
);
  logic [15:0]   lfsr;
  logic          vblnk_q, tick;
  cheese_state_t state;
  logic [5:0]    retry_cnt;
  pos_if         pend;
  logic [10:0]   cx, cy;
  logic          in_lim, accept, cur_hit;
`ifdef CHEESE_TIMEOUT_EN
  logic [9:0]    frame_cnt;
`endif

  cheese_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .value(lfsr));

  assign cx = lfsr[10:0];
  assign cy = {1'b0, lfsr[15:6]};

  assign in_lim = (cx >= X_MIN) && ({1'b0, cx} + 12'(CHEESE_WIDTH) <= {1'b0, X_MAX}) &&
                  (cy >= Y_MIN) && ({1'b0, cy} + 12'(CHEESE_HEIGHT) <= {1'b0, Y_MAX});
  assign accept  = in_lim && !overlap(cx, cy, jerry_x, jerry_y);
  assign cur_hit = overlap(pout.x, pout.y, jerry_x, jerry_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vblnk_q   <= 1'b0;
      tick      <= 1'b0;
      retry_cnt <= '0;
      pend      <= {CHEESE_X0, CHEESE_Y0};
      pout      <= {CHEESE_X0, CHEESE_Y0};
      score     <= '0;
      eaten     <= 1'b0;
`ifdef CHEESE_TIMEOUT_EN
      frame_cnt <= '0;
`endif
    end else begin
      vblnk_q <= vblnk;
      tick    <= vblnk & ~vblnk_q;
      eaten   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= PLACE;
          retry_cnt <= '0;
        end
        PLACE: begin
          if (accept) begin
            pend  <= {cx, cy};
            state <= COMMIT;
          end else if (retry_cnt == RETRY_MAX - 6'd1) begin
            // Out of candidates: fall back to the known-safe home spot.
            pend  <= {CHEESE_X0, CHEESE_Y0};
            state <= COMMIT;
          end else begin
            retry_cnt <= retry_cnt + 6'd1;
          end
        end
        COMMIT: if (tick) begin
          pout  <= pend;
          state <= SHOW;
`ifdef CHEESE_TIMEOUT_EN
          frame_cnt <= '0;
`endif
        end
        SHOW: if (tick) begin
          if (cur_hit) begin
            state <= EATEN;
            eaten <= 1'b1;
            if (score != '1) score <= score + 1'b1;
          end
`ifdef CHEESE_TIMEOUT_EN
          else if (frame_cnt == TIMEOUT_FRAMES - 10'd1) begin
            state     <= PLACE;
            retry_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
          end
`endif
        end
        EATEN: begin
          state     <= PLACE;
          retry_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cheese_ctl.sv
// Bench for cheese_ctl: frame-level behavioural model compared every cycle, plus literal checks.
module tb_cheese_ctl;
  localparam int CW = 32, CH = 32, JW = 40, JH = 48;
  localparam int FRAME = 48, VB_ON = 40, JMOVE = 36;
`ifdef CHEESE_TIMEOUT_EN
  localparam int TO = 3;
`endif

  logic clk = 0, rst = 1, start = 0, vblnk = 0;
  logic [10:0] jerry_x = 0, jerry_y = 0;
  game_pkg::pos_if pout;
  logic [7:0] score;
  logic eaten;

`ifdef CHEESE_TIMEOUT_EN
  cheese_ctl #(.TIMEOUT_FRAMES(10'd3)) dut (.clk(clk), .rst(rst), .start(start), .vblnk(vblnk),
    .jerry_x(jerry_x), .jerry_y(jerry_y), .pout(pout), .score(score), .eaten(eaten));
`else
  cheese_ctl dut (.clk(clk), .rst(rst), .start(start), .vblnk(vblnk),
    .jerry_x(jerry_x), .jerry_y(jerry_y), .pout(pout), .score(score), .eaten(eaten));
`endif

  always #5 clk = ~clk;

  int tests = 0, fails = 0, eaten_seen = 0;
  bit armed = 0;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Model helpers, written from the game rules rather than the hardware structure.
  function automatic logic [15:0] step(logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction
  function automatic bit ovl(int cx, int cy, int jx, int jy);
    return (jx < cx + CW) && (jx + JW > cx) && (jy < cy + CH) && (jy + JH > cy);
  endfunction
  function automatic bit legal(int cx, int cy);
    return cx >= 16 && cx + CW <= 1000 && cy >= 64 && cy + CH <= 740;
  endfunction

  typedef enum int {M_IDLE, M_PLACE, M_SHOW, M_EATEN} mstate_t;
  mstate_t st;
  logic [15:0] lf;
  int pos_x_m = 500, pos_y_m = 400, score_m = 0, pend_x, pend_y, ready, cyc = 0, fc = 0;
  bit eaten_m = 0, tk = 0, vq = 0;

  // Search the next 32 LFSR values (placement starts the cycle after this one).
  task automatic begin_place();
    logic [15:0] v;
    int cx, cy;
    bit found;
    v = step(lf); found = 0;
    pend_x = 500; pend_y = 400; ready = cyc + 33;
    for (int i = 0; i < 32; i++) begin
      cx = int'(v[10:0]); cy = int'(v[15:6]);
      if (!found && legal(cx, cy) && !ovl(cx, cy, int'(jerry_x), int'(jerry_y))) begin
        pend_x = cx; pend_y = cy; ready = cyc + i + 2; found = 1;
      end
      v = step(v);
    end
    st = M_PLACE;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      lf = 16'hACE1; st = M_IDLE; pos_x_m = 500; pos_y_m = 400; score_m = 0;
      eaten_m = 0; tk = 0; vq = 0; fc = 0; armed = 1;
    end else begin
      eaten_m = 0;
      case (st)
        M_IDLE:  if (start) begin_place();
        M_PLACE: if (tk && cyc >= ready) begin
          pos_x_m = pend_x; pos_y_m = pend_y; st = M_SHOW; fc = 0;
        end
        M_SHOW: if (tk) begin
          if (ovl(pos_x_m, pos_y_m, int'(jerry_x), int'(jerry_y))) begin
            eaten_m = 1; st = M_EATEN;
            if (score_m < 255) score_m = score_m + 1;
          end
`ifdef CHEESE_TIMEOUT_EN
          else begin
            fc = fc + 1;
            if (fc == TO) begin_place();
          end
`endif
        end
        M_EATEN: begin_place();
        default: st = M_IDLE;
      endcase
      tk = vblnk && !vq;
      vq = vblnk;
      lf = step(lf);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pout_x", int'(pout.x), pos_x_m);
      chk("pout_y", int'(pout.y), pos_y_m);
      chk("score", int'(score), score_m);
      chk("eaten", int'(eaten), int'(eaten_m));
      if (eaten) eaten_seen++;
    end
  end

  // Jerry stimulus: fixed spot or offset from the model's current cheese.
  int jmode = 0, jfx = 0, jfy = 0, jdx = 0, jdy = 0;
  task automatic cycles(input int lo, input int hi);
    for (int c = lo; c < hi; c++) begin
      @(negedge clk);
      vblnk = (c >= VB_ON);
      if (c == JMOVE) begin
        if (jmode == 0) begin jerry_x = 11'(jfx); jerry_y = 11'(jfy); end
        else begin jerry_x = 11'(pos_x_m + jdx); jerry_y = 11'(pos_y_m + jdy); end
      end
    end
  endtask
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) cycles(0, FRAME);
  endtask

  int e0;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", int'(pout.x), 500);
    chk("rst_y", int'(pout.y), 400);
    chk("rst_score", int'(score), 0);
    chk("rst_eaten", int'(eaten), 0);
    rst = 0;

    chk("lfsr_step1", int'(step(16'hACE1)), 16'hE270);
    chk("lfsr_step2", int'(step(16'hE270)), 16'h7138);
    chk("ovl_right_touch", int'(ovl(100, 100, 132, 100)), 0);
    chk("ovl_right_in", int'(ovl(100, 100, 131, 100)), 1);
    chk("ovl_left_touch", int'(ovl(100, 100, 60, 100)), 0);
    chk("ovl_left_in", int'(ovl(100, 100, 61, 100)), 1);

    run_frames(5);
    chk("idle_x", int'(pout.x), 500);
    chk("idle_y", int'(pout.y), 400);
    chk("idle_eaten_cnt", eaten_seen, 0);

    start = 1;
    cycles(0, VB_ON);
    chk("pre_tick_x", int'(pout.x), 500);
    chk("pre_tick_y", int'(pout.y), 400);
    cycles(VB_ON, FRAME);
    chk("placed_legal", int'(legal(int'(pout.x), int'(pout.y))), 1);

    jmode = 1; jdx = 0; jdy = 0;
    run_frames(1);
    chk("first_eat_score", int'(score), 1);
    chk("first_eat_cnt", eaten_seen, 1);
    run_frames(1);

    jdx = CW;
    run_frames(2);
    chk("touch_score", int'(score), 1);
    jdx = CW - 1;
    run_frames(1);
    chk("one_px_in_score", int'(score), 2);
    run_frames(1);

`ifdef CHEESE_TIMEOUT_EN
    jmode = 0; jfx = 0; jfy = 0;
    e0 = eaten_seen;
    run_frames(4);
    chk("timeout_score", int'(score), 2);
    chk("timeout_no_eat", eaten_seen - e0, 0);
    run_frames(2);
    jmode = 1; jdx = 0;
    run_frames(1);
    chk("timeout_overlap_wins", int'(score), 3);
    run_frames(1);
`endif

    @(negedge clk); vblnk = 0; rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_x", int'(pout.x), 500);
    chk("midrst_y", int'(pout.y), 400);
    chk("midrst_score", int'(score), 0);
    rst = 0;

    jmode = 1; jdx = 0; jdy = 0;
    e0 = eaten_seen;
    run_frames(520);
    chk("sat_score", int'(score), 255);
    chk("sat_pulses", int'(eaten_seen - e0 >= 256), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
